// File: rtl/tube_renderer.sv
// Tube column renderer: owns tube scroll/gap/score state, addresses the tube
// sprite ROM and composites the opaque tube pixels over the background stream.
module tube_renderer #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned TUBE_W    = 16,
    parameter int unsigned GAP_H     = 120,
    parameter int unsigned GAP_MIN   = 40,
    parameter int unsigned SPEED     = 2,
    parameter int unsigned BIRD_X    = 100,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        run,
    input  logic        restart,
    input  logic        pix_valid,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic [7:0]  bg_r,
    input  logic [7:0]  bg_g,
    input  logic [7:0]  bg_b,
    output logic [10:0] spr_ix,
    output logic [10:0] spr_iy,
    input  logic [7:0]  spr_r,
    input  logic [7:0]  spr_g,
    input  logic [7:0]  spr_b,
    input  logic        spr_mask,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_valid,
    output logic        tube_px,
    output logic [10:0] tube_x,
    output logic [10:0] gap_y,
    output logic        score_pulse
);

    localparam int unsigned XW = 11;
    localparam int unsigned EW = 12;
    localparam logic [XW-1:0] TX_RST  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] GAP_RST = XW'(GAP_MIN) + {3'b0, LFSR_SEED};

    logic [XW-1:0] tube_x_q, tube_x_d;
    logic [XW-1:0] gap_y_q, gap_y_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          score_q, score_d;

    logic [7:0]    lfsr_next;
    logic [XW-1:0] tx_moved;
    logic [EW-1:0] old_end, new_end;

    // Game state: restart beats frame_tick; wrap reloads x and draws a new gap
    always_comb begin
        tube_x_d  = tube_x_q;
        gap_y_d   = gap_y_q;
        lfsr_d    = lfsr_q;
        score_d   = 1'b0;
        lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        tx_moved  = tube_x_q - XW'(SPEED);
        old_end   = {1'b0, tube_x_q} + EW'(TUBE_W);
        new_end   = {1'b0, tx_moved} + EW'(TUBE_W);
        if (restart) begin
            tube_x_d = TX_RST;
            gap_y_d  = GAP_RST;
            lfsr_d   = LFSR_SEED;
        end else if (frame_tick && run) begin
            if (tube_x_q < XW'(SPEED)) begin
                tube_x_d = TX_RST;
                lfsr_d   = lfsr_next;
                gap_y_d  = XW'(GAP_MIN) + {3'b0, lfsr_next};
            end else begin
                tube_x_d = tx_moved;
                score_d  = (old_end > EW'(BIRD_X)) && (new_end <= EW'(BIRD_X));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tube_x_q <= TX_RST;
            gap_y_q  <= GAP_RST;
            lfsr_q   <= LFSR_SEED;
            score_q  <= 1'b0;
        end else begin
            tube_x_q <= tube_x_d;
            gap_y_q  <= gap_y_d;
            lfsr_q   <= lfsr_d;
            score_q  <= score_d;
        end
    end

    // Stage 0: tube hit test on the live raster position (12-bit compares)
    logic          in_col, in_tube;
    logic [EW-1:0] h_ext, tx_ext, gap_end;
    logic [3:0]    col_d;

    always_comb begin
        h_ext   = {1'b0, hcount};
        tx_ext  = {1'b0, tube_x_q};
        gap_end = {1'b0, gap_y_q} + EW'(GAP_H);
        in_col  = pix_valid && (h_ext >= tx_ext) && (h_ext < tx_ext + EW'(TUBE_W));
        in_tube = in_col && (vcount < XW'(V_ACTIVE)) &&
                  ((vcount < gap_y_q) || ({1'b0, vcount} >= gap_end));
        col_d   = hcount[3:0] - tube_x_q[3:0];
    end

    assign spr_iy = {7'b0, vcount[3:0]};

    // Stage 1 registers; ROM answers combinationally within this stage
    logic       in_tube_s1_q, valid_s1_q;
    logic [3:0] col_s1_q;
    logic [7:0] bg_r_s1_q, bg_g_s1_q, bg_b_s1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_tube_s1_q <= 1'b0;
            valid_s1_q   <= 1'b0;
            col_s1_q     <= 4'd0;
            bg_r_s1_q    <= 8'd0;
            bg_g_s1_q    <= 8'd0;
            bg_b_s1_q    <= 8'd0;
        end else begin
            in_tube_s1_q <= in_tube;
            valid_s1_q   <= pix_valid;
            col_s1_q     <= col_d;
            bg_r_s1_q    <= bg_r;
            bg_g_s1_q    <= bg_g;
            bg_b_s1_q    <= bg_b;
        end
    end

    // Column 16 lies outside the sprite so the ROM reports transparent
    assign spr_ix = in_tube_s1_q ? {7'b0, col_s1_q} : 11'd16;

    // Stage 2: composite and register outputs
    logic       opaque;
    logic [7:0] o_r_d, o_g_d, o_b_d;
    logic [7:0] o_r_q, o_g_q, o_b_q;
    logic       o_valid_q, tube_px_q;

    always_comb begin
        opaque = in_tube_s1_q && spr_mask;
        o_r_d  = opaque ? spr_r : bg_r_s1_q;
        o_g_d  = opaque ? spr_g : bg_g_s1_q;
        o_b_d  = opaque ? spr_b : bg_b_s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_r_q     <= 8'd0;
            o_g_q     <= 8'd0;
            o_b_q     <= 8'd0;
            o_valid_q <= 1'b0;
            tube_px_q <= 1'b0;
        end else begin
            o_r_q     <= o_r_d;
            o_g_q     <= o_g_d;
            o_b_q     <= o_b_d;
            o_valid_q <= valid_s1_q;
            tube_px_q <= opaque;
        end
    end

    assign o_r         = o_r_q;
    assign o_g         = o_g_q;
    assign o_b         = o_b_q;
    assign o_valid     = o_valid_q;
    assign tube_px     = tube_px_q;
    assign tube_x      = tube_x_q;
    assign gap_y       = gap_y_q;
    assign score_pulse = score_q;

endmodule
